bcd_scan_driver: RTL

- Four-digit BCD event counter with a built-in time-multiplexed seven-segment scan stage.
- Counts qualified increment pulses from 0000 to 9999.
- Cycles a one-hot digit select and drives segments A–G for the currently selected digit.
- Sits upstream of the chip-level display pins and shell. It feeds the segment, select and scan-strobe signals the shell routes to the pad ring.

---
 rtl/bcd_scan_pkg.sv | 40 ++++
 rtl/bcd_scan_driver_seg7_decode.sv | 27 ++
 rtl/bcd_scan_driver.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/bcd_scan_pkg.sv
// Shared types and constants for the BCD event counter and its seven-segment scan stage.
`timescale 1ns/1ps
package bcd_scan_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;

    localparam logic [3:0] SEL_RESET = 4'b0001;

    // Four-digit BCD increment; bit 16 of the result is the wrap carry out of 9999.
    function automatic logic [16:0] bcd_inc4(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (v[4*i +: 4] >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return {c, r};
    endfunction

endpackage

// File: rtl/bcd_scan_driver_seg7_decode.sv
// Combinational BCD digit to seven-segment (GFEDCBA, active-high) lookup.
`timescale 1ns/1ps
module seg7_decode
    import bcd_scan_pkg::*;
(
    input  bcd_digit_t i_digit,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_digit)
            4'd0: o_seg = SEG_0;
            4'd1: o_seg = SEG_1;
            4'd2: o_seg = SEG_2;
            4'd3: o_seg = SEG_3;
            4'd4: o_seg = SEG_4;
            4'd5: o_seg = SEG_5;
            4'd6: o_seg = SEG_6;
            4'd7: o_seg = SEG_7;
            4'd8: o_seg = SEG_8;
            4'd9: o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_scan_driver.sv
// Four-digit BCD event counter with a time-multiplexed, anti-ghosted seven-segment scan.
// Every output is registered; no input reaches an output combinationally.
`timescale 1ns/1ps
module bcd_scan_driver
    import bcd_scan_pkg::*;
#(
    parameter int SCAN_DIV    = 1024,
    parameter int BLANK_CYC   = 2,
    parameter int LZ_SUPPRESS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    input  logic        clr,
    output logic [6:0]  seg,
    output logic [3:0]  sel,
    output logic        scan_stb,
    output logic [15:0] value,
    output logic        carry
);

    localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_TC   = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] BLANK_LD = DIV_W'(BLANK_CYC);

    logic [15:0]      r_value;
    logic             r_carry;
    logic [DIV_W-1:0] r_div;
    logic             r_stb;
    logic [3:0]       r_sel;
    logic [DIV_W-1:0] r_blank;
    logic [6:0]       r_seg;

    logic [16:0]      w_inc_res;
    logic             w_tc;
    logic [3:0]       w_sel_next;
    logic [DIV_W-1:0] w_blank_next;
    logic [3:0]       w_lead_zero;
    bcd_digit_t       w_digit;
    logic             w_lz_blank;
    logic [6:0]       w_seg_dec;
    logic [6:0]       w_seg_next;

    assign w_inc_res = bcd_inc4(r_value);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
            r_carry <= 1'b0;
        end else begin
            r_carry <= 1'b0;
            if (clr) begin
                r_value <= '0;
            end else if (inc) begin
                r_value <= w_inc_res[15:0];
                r_carry <= w_inc_res[16];
            end
        end
    end

    assign w_tc = (r_div == DIV_TC);

    // A non-one-hot select can only come from an upset; fall back to digit 0.
    always_comb begin
        w_sel_next = r_sel;
        if (!$onehot(r_sel)) begin
            w_sel_next = SEL_RESET;
        end else if (w_tc) begin
            w_sel_next = {r_sel[2:0], r_sel[3]};
        end
    end

    always_comb begin
        w_blank_next = '0;
        if (w_tc) begin
            w_blank_next = BLANK_LD;
        end else if (r_blank != '0) begin
            w_blank_next = r_blank - DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div   <= '0;
            r_stb   <= 1'b0;
            r_sel   <= SEL_RESET;
            r_blank <= BLANK_LD;
        end else begin
            r_div   <= w_tc ? '0 : r_div + DIV_W'(1);
            r_stb   <= w_tc;
            r_sel   <= w_sel_next;
            r_blank <= w_blank_next;
        end
    end

    assign w_lead_zero[3] = (r_value[15:12] == 4'd0);
    assign w_lead_zero[2] = w_lead_zero[3] && (r_value[11:8] == 4'd0);
    assign w_lead_zero[1] = w_lead_zero[2] && (r_value[7:4] == 4'd0);
    assign w_lead_zero[0] = 1'b0;

    // The mux follows the select being loaded this edge so seg and sel stay aligned.
    always_comb begin
        w_digit    = r_value[3:0];
        w_lz_blank = 1'b0;
        case (w_sel_next)
            4'b0010: begin
                w_digit    = r_value[7:4];
                w_lz_blank = w_lead_zero[1];
            end
            4'b0100: begin
                w_digit    = r_value[11:8];
                w_lz_blank = w_lead_zero[2];
            end
            4'b1000: begin
                w_digit    = r_value[15:12];
                w_lz_blank = w_lead_zero[3];
            end
            default: begin
                w_digit    = r_value[3:0];
                w_lz_blank = 1'b0;
            end
        endcase
    end

    seg7_decode u_seg7_decode (
        .i_digit (w_digit),
        .o_seg   (w_seg_dec)
    );

    always_comb begin
        w_seg_next = w_seg_dec;
        if (w_blank_next != '0) begin
            w_seg_next = SEG_BLANK;
        end else if ((LZ_SUPPRESS != 0) && w_lz_blank) begin
            w_seg_next = SEG_BLANK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= SEG_BLANK;
        end else begin
            r_seg <= w_seg_next;
        end
    end

    assign seg      = r_seg;
    assign sel      = r_sel;
    assign scan_stb = r_stb;
    assign value    = r_value;
    assign carry    = r_carry;

endmodule
